// File: rtl/sprite_store_param.sv
// Per-line sprite store: captures OAM scan matches in arrival order and serves
// the lowest-slot X match during pixel transfer. Optional bus hold: SPRITE_STORE_BUSHOLD_EN.
module sprite_store_param #(
  parameter int unsigned SLOTS  = 10,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned LINE_W = 4,
  parameter int unsigned X_W    = 8,
  parameter int unsigned CNT_W  = $clog2(SLOTS + 1)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              scan_start,
  input  logic              store_valid,
  input  logic [IDX_W-1:0]  store_idx,
  input  logic [LINE_W-1:0] store_line,
  input  logic [X_W-1:0]    store_x,
  input  logic [X_W-1:0]    pix_x,
  input  logic              fetch_done,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_slot,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [LINE_W-1:0] hit_line
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [SLOTS-1:0]  valid_q, valid_d;
  logic [SLOTS-1:0]  match, win_oh, wr_en;
  logic [IDX_W-1:0]  idx_q  [SLOTS];
  logic [LINE_W-1:0] line_q [SLOTS];
  logic [X_W-1:0]    x_q    [SLOTS];

  logic              win_found;
  logic [CNT_W-1:0]  win_slot;
  logic [IDX_W-1:0]  win_idx;
  logic [LINE_W-1:0] win_line;
  logic              full_int;
  logic              store_en;

  assign full_int = (count_q == CNT_W'(SLOTS));
  assign store_en = store_valid && !full_int && !scan_start;

  // Priority lookup: first matching slot in ascending order is the earliest stored.
  always_comb begin
    match     = '0;
    win_oh    = '0;
    win_found = 1'b0;
    win_slot  = '0;
    win_idx   = '0;
    win_line  = '0;
    for (int i = 0; i < int'(SLOTS); i++) begin
      match[i] = valid_q[i] && (x_q[i] == pix_x);
      if (match[i] && !win_found) begin
        win_found = 1'b1;
        win_oh[i] = 1'b1;
        win_slot  = CNT_W'(i);
        win_idx   = idx_q[i];
        win_line  = line_q[i];
      end
    end
  end

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < int'(SLOTS); i++) begin
      wr_en[i] = store_en && (count_q == CNT_W'(i));
    end
  end

  // Retire and store never collide: the write slot is never yet valid.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (scan_start) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      if (fetch_done) begin
        valid_d = valid_d & ~win_oh;
      end
      valid_d = valid_d | wr_en;
      if (store_en) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload fields are qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(SLOTS); i++) begin
      if (wr_en[i]) begin
        idx_q[i]  <= store_idx;
        line_q[i] <= store_line;
        x_q[i]    <= store_x;
      end
    end
  end

`ifdef SPRITE_STORE_BUSHOLD_EN
  logic [CNT_W-1:0]  hold_slot_q;
  logic [IDX_W-1:0]  hold_idx_q;
  logic [LINE_W-1:0] hold_line_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hold_slot_q <= '0;
      hold_idx_q  <= '0;
      hold_line_q <= '0;
    end else if (win_found) begin
      hold_slot_q <= win_slot;
      hold_idx_q  <= win_idx;
      hold_line_q <= win_line;
    end
  end

  assign hit_slot = win_found ? win_slot : hold_slot_q;
  assign hit_idx  = win_found ? win_idx  : hold_idx_q;
  assign hit_line = win_found ? win_line : hold_line_q;
`else
  assign hit_slot = win_slot;
  assign hit_idx  = win_idx;
  assign hit_line = win_line;
`endif

  assign hit   = win_found;
  assign count = count_q;
  assign full  = full_int;

endmodule

// File: tb/tb_sprite_store_param.sv
// Self-checking bench for sprite_store_param: directed scenarios plus random traffic
// against a slot-array reference model.
module tb_sprite_store_param;
  localparam int SLOTS  = 10;
  localparam int IDX_W  = 6;
  localparam int LINE_W = 4;
  localparam int X_W    = 8;
  localparam int CNT_W  = 4;
`ifdef SPRITE_STORE_BUSHOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              scan_start = 1'b0;
  logic              store_valid = 1'b0;
  logic              fetch_done = 1'b0;
  logic [IDX_W-1:0]  store_idx = '0;
  logic [LINE_W-1:0] store_line = '0;
  logic [X_W-1:0]    store_x = '0;
  logic [X_W-1:0]    pix_x = '0;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              hit;
  logic [CNT_W-1:0]  hit_slot;
  logic [IDX_W-1:0]  hit_idx;
  logic [LINE_W-1:0] hit_line;

  sprite_store_param #(
    .SLOTS (SLOTS),
    .IDX_W (IDX_W),
    .LINE_W(LINE_W),
    .X_W   (X_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .scan_start (scan_start),
    .store_valid(store_valid),
    .store_idx  (store_idx),
    .store_line (store_line),
    .store_x    (store_x),
    .pix_x      (pix_x),
    .fetch_done (fetch_done),
    .count      (count),
    .full       (full),
    .hit        (hit),
    .hit_slot   (hit_slot),
    .hit_idx    (hit_idx),
    .hit_line   (hit_line)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a list of captured sprites with a live flag each.
  bit                m_valid [SLOTS];
  int                m_idx   [SLOTS];
  int                m_line  [SLOTS];
  int                m_x     [SLOTS];
  int                m_count;
  logic [CNT_W-1:0]  h_slot;
  logic [IDX_W-1:0]  h_idx;
  logic [LINE_W-1:0] h_line;

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) m_valid[i] = 1'b0;
    m_count = 0;
  endtask

  task automatic model_out(input int px, output logic eh, output logic [CNT_W-1:0] es,
                           output logic [IDX_W-1:0] ei, output logic [LINE_W-1:0] el);
    eh = 1'b0;
    es = HOLD ? h_slot : '0;
    ei = HOLD ? h_idx  : '0;
    el = HOLD ? h_line : '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!eh && m_valid[i] && m_x[i] == px) begin
        eh = 1'b1;
        es = CNT_W'(i);
        ei = IDX_W'(m_idx[i]);
        el = LINE_W'(m_line[i]);
      end
    end
  endtask

  task automatic set_in(input bit sc, input bit sv, input bit fd,
                        input int idx, input int line, input int x, input int px);
    scan_start  = sc;
    store_valid = sv;
    fetch_done  = fd;
    store_idx   = IDX_W'(idx);
    store_line  = LINE_W'(line);
    store_x     = X_W'(x);
    pix_x       = X_W'(px);
  endtask

  // Advance the model by the inputs currently applied, then clock the DUT.
  task automatic tick();
    logic eh;
    logic [CNT_W-1:0] es;
    logic [IDX_W-1:0] ei;
    logic [LINE_W-1:0] el;
    model_out(int'(pix_x), eh, es, ei, el);
    if (eh) begin
      h_slot = es;
      h_idx  = ei;
      h_line = el;
    end
    if (scan_start) begin
      model_clear();
    end else begin
      if (fetch_done && eh) m_valid[es] = 1'b0;
      if (store_valid && m_count < SLOTS) begin
        m_valid[m_count] = 1'b1;
        m_idx[m_count]   = int'(store_idx);
        m_line[m_count]  = int'(store_line);
        m_x[m_count]     = int'(store_x);
        m_count++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int idx, input int line, input int x);
    set_in(1'b0, 1'b1, 1'b0, idx, line, x, int'(pix_x));
    tick();
    store_valid = 1'b0;
  endtask

  task automatic do_clear();
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, int'(pix_x));
    tick();
    scan_start = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    model_clear();
    h_slot = '0;
    h_idx  = '0;
    h_line = '0;
    #2;
    checks++;
    if ({count, full, hit, hit_slot, hit_idx, hit_line} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got count=%0d full=%0b hit=%0b slot=%0d idx=%0d line=%0d want all 0",
               count, full, hit, hit_slot, hit_idx, hit_line);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_retire();
    do_clear();
    do_store(5, 1, 20);
    do_store(7, 2, 30);
    do_store(9, 3, 20);
    pix_x = 8'd20;
    #1;
    checks++;
    if (count !== 4'd3) begin
      errors++; $display("FAIL basic_count got=%0d want=3", count);
    end
    checks++;
    if ({hit, hit_slot, hit_idx, hit_line} !== {1'b1, 4'd0, 6'd5, 4'd1}) begin
      errors++;
      $display("FAIL basic_hit got hit=%0b slot=%0d idx=%0d line=%0d want 1/0/5/1",
               hit, hit_slot, hit_idx, hit_line);
    end
    fetch_done = 1'b1;
    tick();
    checks++;
    if ({hit, hit_slot, hit_idx, hit_line} !== {1'b1, 4'd2, 6'd9, 4'd3}) begin
      errors++;
      $display("FAIL retire_next got hit=%0b slot=%0d idx=%0d line=%0d want 1/2/9/3",
               hit, hit_slot, hit_idx, hit_line);
    end
    tick();
    fetch_done = 1'b0;
    #1;
    checks++;
    if (hit !== 1'b0 || hit_idx !== (HOLD ? 6'd9 : 6'd0)) begin
      errors++;
      $display("FAIL retire_drain got hit=%0b idx=%0d want hit=0 idx=%0d",
               hit, hit_idx, HOLD ? 9 : 0);
    end
    pix_x = 8'd30;
    #1;
    checks++;
    if ({hit, hit_slot, hit_idx} !== {1'b1, 4'd1, 6'd7}) begin
      errors++;
      $display("FAIL retire_other got hit=%0b slot=%0d idx=%0d want 1/1/7", hit, hit_slot, hit_idx);
    end
  endtask

  task automatic test_full();
    int bad;
    do_clear();
    for (int i = 0; i < 12; i++) do_store(10 + i, i, 100 + i);
    checks++;
    if (count !== 4'd10 || full !== 1'b1) begin
      errors++; $display("FAIL full_count got count=%0d full=%0b want 10/1", count, full);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      pix_x = X_W'(100 + i);
      #1;
      if (hit !== (i < 10)) bad++;
      if (i < 10 && hit_slot !== CNT_W'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_lookup got %0d bad lookups want 0", bad);
    end
  endtask

  task automatic test_clear_collision();
    int bad;
    do_clear();
    for (int i = 0; i < 4; i++) do_store(40 + i, i, 50 + i);
    checks++;
    if (count !== 4'd4) begin
      errors++; $display("FAIL collide_pre_count got=%0d want=4", count);
    end
    set_in(1'b1, 1'b1, 1'b0, 33, 2, 60, 50);
    tick();
    scan_start  = 1'b0;
    store_valid = 1'b0;
    checks++;
    if (count !== 4'd0 || full !== 1'b0) begin
      errors++; $display("FAIL collide_count got count=%0d full=%0b want 0/0", count, full);
    end
    bad = 0;
    for (int px = 0; px < 256; px++) begin
      pix_x = X_W'(px);
      #1;
      if (hit !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL collide_hit got %0d pix_x with hit want 0", bad);
    end
  endtask

  task automatic test_reset_midscan();
    do_clear();
    for (int i = 0; i < 6; i++) do_store(20 + i, i, 70 + i);
    pix_x = 8'd70;
    #1;
    checks++;
    if (count !== 4'd6 || hit !== 1'b1) begin
      errors++; $display("FAIL midscan_pre got count=%0d hit=%0b want 6/1", count, hit);
    end
    #1;
    nreset = 1'b0;
    #1;
    checks++;
    if ({count, full, hit, hit_slot, hit_idx, hit_line} !== '0) begin
      errors++;
      $display("FAIL midscan_async got count=%0d hit=%0b slot=%0d idx=%0d line=%0d want all 0",
               count, hit, hit_slot, hit_idx, hit_line);
    end
    model_clear();
    h_slot = '0;
    h_idx  = '0;
    h_line = '0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold();
    do_clear();
    do_store(7, 4, 40);
    pix_x = 8'd40;
    #1;
    checks++;
    if (hit !== 1'b1 || hit_idx !== 6'd7) begin
      errors++; $display("FAIL hold_hit got hit=%0b idx=%0d want 1/7", hit, hit_idx);
    end
    tick();
    pix_x = 8'd41;
    #1;
    checks++;
    if (hit !== 1'b0 || hit_idx !== (HOLD ? 6'd7 : 6'd0) || hit_line !== (HOLD ? 4'd4 : 4'd0)) begin
      errors++;
      $display("FAIL hold_miss got hit=%0b idx=%0d line=%0d want 0/%0d/%0d",
               hit, hit_idx, hit_line, HOLD ? 7 : 0, HOLD ? 4 : 0);
    end
  endtask

  task automatic test_random();
    logic eh;
    logic [CNT_W-1:0] es;
    logic [IDX_W-1:0] ei;
    logic [LINE_W-1:0] el;
    do_clear();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             $urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 7),
             $urandom_range(0, 7));
      #1;
      model_out(int'(pix_x), eh, es, ei, el);
      checks++;
      if (count !== CNT_W'(m_count) || full !== (m_count == SLOTS)) begin
        errors++;
        $display("FAIL rand_count n=%0d got count=%0d full=%0b want %0d/%0b",
                 n, count, full, m_count, m_count == SLOTS);
      end
      checks++;
      if ({hit, hit_slot, hit_idx, hit_line} !== {eh, es, ei, el}) begin
        errors++;
        $display("FAIL rand_lookup n=%0d got hit=%0b slot=%0d idx=%0d line=%0d want %0b/%0d/%0d/%0d",
                 n, hit, hit_slot, hit_idx, hit_line, eh, es, ei, el);
      end
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_retire();
    test_full();
    test_clear_collision();
    test_reset_midscan();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
